// File: rtl/switch_control.sv
// rtl/switch_control.sv - XY-routing switch allocator for a 5-port mesh router
module switch_control #(
    parameter int          NPORT    = 5,
    parameter int          TAM_FLIT = 16,
    parameter logic [7:0]  ADDRESS  = 8'h00
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NPORT-1:0]                   h,
    input  logic [NPORT*TAM_FLIT-1:0]          data,
    input  logic [NPORT-1:0]                   sender,
    output logic [NPORT-1:0]                   ack_h,
    output logic [NPORT-1:0]                   arb_requests,
    output logic                               arb_enable,
    input  logic [$clog2(NPORT)-1:0]           arb_selected,
    output logic [NPORT-1:0]                   free,
    output logic [NPORT*$clog2(NPORT)-1:0]     mux_in
);

    localparam int SW = $clog2(NPORT);

    localparam logic [SW-1:0] P_EAST  = SW'(0);
    localparam logic [SW-1:0] P_WEST  = SW'(1);
    localparam logic [SW-1:0] P_NORTH = SW'(2);
    localparam logic [SW-1:0] P_SOUTH = SW'(3);
    localparam logic [SW-1:0] P_LOCAL = SW'(4);

    localparam logic [3:0] X_ADDR = ADDRESS[7:4];
    localparam logic [3:0] Y_ADDR = ADDRESS[3:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ROUTE = 2'd2,
        S_GRANT = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   dest;
    logic [SW-1:0]   mux_q [NPORT];

    // Only the low address byte of each head flit takes part in routing.
    logic [7:0]      head_addr [NPORT];
    logic [7:0]      cur_addr;
    logic [3:0]      xt;
    logic [3:0]      yt;
    logic [SW-1:0]   dest_c;
    logic            sel_ok;
    logic            grant_ok;
    logic            unused_data;

    assign unused_data = ^data;

    for (genvar i = 0; i < NPORT; i++) begin : g_ports
        assign head_addr[i]          = data[i*TAM_FLIT +: 8];
        assign mux_in[i*SW +: SW]    = mux_q[i];
    end

    always_comb begin
        sel_ok   = int'(arb_selected) < NPORT;
        cur_addr = sel_ok ? head_addr[arb_selected] : 8'h00;
        xt       = cur_addr[7:4];
        yt       = cur_addr[3:0];
        dest_c   = P_LOCAL;
        if (xt > X_ADDR)
            dest_c = P_EAST;
        else if (xt < X_ADDR)
            dest_c = P_WEST;
        else if (yt > Y_ADDR)
            dest_c = P_NORTH;
        else if (yt < Y_ADDR)
            dest_c = P_SOUTH;
        grant_ok = sel_ok && h[arb_selected] && free[dest_c];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (|h) next_state = S_ARB;
            S_ARB:   next_state = S_ROUTE;
            S_ROUTE: next_state = grant_ok ? S_GRANT : S_IDLE;
            S_GRANT: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Registered outputs and allocation state; release runs every cycle
    // and a grant can never target an output that is being released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_h        <= '0;
            arb_enable   <= 1'b0;
            arb_requests <= '0;
            free         <= '1;
            sel          <= '0;
            dest         <= '0;
            for (int o = 0; o < NPORT; o++)
                mux_q[o] <= '0;
        end else begin
            arb_enable <= (next_state == S_ARB);
            ack_h      <= '0;
            if (state == S_IDLE && |h)
                arb_requests <= h;
            if (state == S_ROUTE) begin
                sel  <= arb_selected;
                dest <= dest_c;
            end
            for (int o = 0; o < NPORT; o++) begin
                if (!free[o] && !sender[mux_q[o]])
                    free[o] <= 1'b1;
            end
            if (state == S_GRANT) begin
                ack_h[sel]  <= 1'b1;
                free[dest]  <= 1'b0;
                mux_q[dest] <= sel;
            end
        end
    end

endmodule
